// File: rtl/afifo_pkg.sv
// Shared pointer helpers for the dual-clock FIFO: Gray/binary conversion and depth.
// Callers zero-extend their pointers to PTR_W_MAX bits and truncate the result.
package afifo_pkg;

    localparam int unsigned PTR_W_MAX = 32;

    function automatic int unsigned fifo_depth(input int unsigned asize);
        return 32'd1 << asize;
    endfunction

    function automatic logic [PTR_W_MAX-1:0] bin2gray(input logic [PTR_W_MAX-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PTR_W_MAX-1:0] gray2bin(input logic [PTR_W_MAX-1:0] g);
        logic [PTR_W_MAX-1:0] b;
        b[PTR_W_MAX-1] = g[PTR_W_MAX-1];
        for (int i = PTR_W_MAX - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/afifo_gray_sync.sv
// Multi-stage synchroniser carrying a Gray-coded pointer into the destination clock domain.
module afifo_gray_sync
    import afifo_pkg::*;
#(
    parameter int W      = 5,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [STAGES-1:0][W-1:0] sync_q;
    logic [STAGES-1:0][W-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/afifo_prog.sv
// Dual-clock FIFO with registered read data, fill levels in both domains,
// programmable almost-full/almost-empty thresholds and sticky error flags.
module afifo_prog
    import afifo_pkg::*;
#(
    parameter int DSIZE       = 8,
    parameter int ASIZE       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             wclk,
    input  logic             rrst_n,
    input  logic             rclk,
    input  logic [DSIZE-1:0] wdata,
    input  logic             winc,
    input  logic [ASIZE:0]   afull_thresh,
    output logic             wfull,
    output logic             walmost_full,
    output logic [ASIZE:0]   wlevel,
    output logic             woverflow,
    input  logic             rinc,
    input  logic [ASIZE:0]   aempty_thresh,
    output logic [DSIZE-1:0] rdata,
    output logic             rvalid,
    output logic             rempty,
    output logic             ralmost_empty,
    output logic [ASIZE:0]   rlevel,
    output logic             runderflow
);

    localparam int          PW      = ASIZE + 1;
    localparam int unsigned DEPTH   = fifo_depth(ASIZE);
    localparam logic [PW-1:0] DEPTH_L = PW'(DEPTH);

    logic [1:0] wrst_sync_q, wrst_sync_d;
    logic [1:0] rrst_sync_q, rrst_sync_d;
    logic       wrst_n, rd_rst_n;

    // Assertion is immediate in both domains; release waits two local edges.
    always_comb begin
        wrst_sync_d = {wrst_sync_q[0], 1'b1};
        rrst_sync_d = {rrst_sync_q[0], 1'b1};
    end

    always_ff @(posedge wclk or negedge rrst_n) begin
        if (!rrst_n) wrst_sync_q <= '0;
        else         wrst_sync_q <= wrst_sync_d;
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) rrst_sync_q <= '0;
        else         rrst_sync_q <= rrst_sync_d;
    end

    assign wrst_n   = wrst_sync_q[1];
    assign rd_rst_n = rrst_sync_q[1];

    logic [DSIZE-1:0] mem [DEPTH];

    logic [PW-1:0] wbin_q, wbin_d, wgray_q, wgray_d, wlevel_q, wlevel_d, rgray_sync;
    logic          wfull_q, wfull_d, walmost_full_q, walmost_full_d, woverflow_q, woverflow_d;
    logic          wpush;

    logic [PW-1:0]    rbin_q, rbin_d, rgray_q, rgray_d, rlevel_q, rlevel_d, wgray_sync;
    logic             rempty_q, rempty_d, ralmost_empty_q, ralmost_empty_d;
    logic             rvalid_q, rvalid_d, runderflow_q, runderflow_d;
    logic [DSIZE-1:0] rdata_q, rdata_d;
    logic             rpop;

    afifo_gray_sync #(.W(PW), .STAGES(SYNC_STAGES)) u_rptr_sync (
        .clk   (wclk),
        .rst_n (wrst_n),
        .d     (rgray_q),
        .q     (rgray_sync)
    );

    afifo_gray_sync #(.W(PW), .STAGES(SYNC_STAGES)) u_wptr_sync (
        .clk   (rclk),
        .rst_n (rd_rst_n),
        .d     (wgray_q),
        .q     (wgray_sync)
    );

    always_comb begin
        wpush          = winc && !wfull_q;
        wbin_d         = wbin_q + PW'(wpush);
        wgray_d        = PW'(bin2gray(PTR_W_MAX'(wbin_d)));
        wlevel_d       = wbin_d - PW'(gray2bin(PTR_W_MAX'(rgray_sync)));
        wfull_d        = (wlevel_d == DEPTH_L);
        walmost_full_d = (wlevel_d >= afull_thresh);
        woverflow_d    = woverflow_q || (winc && wfull_q);
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin_q         <= '0;
            wgray_q        <= '0;
            wlevel_q       <= '0;
            wfull_q        <= 1'b0;
            walmost_full_q <= 1'b0;
            woverflow_q    <= 1'b0;
        end else begin
            wbin_q         <= wbin_d;
            wgray_q        <= wgray_d;
            wlevel_q       <= wlevel_d;
            wfull_q        <= wfull_d;
            walmost_full_q <= walmost_full_d;
            woverflow_q    <= woverflow_d;
        end
    end

    always_ff @(posedge wclk) begin
        if (wpush) mem[wbin_q[ASIZE-1:0]] <= wdata;
    end

    always_comb begin
        rpop            = rinc && !rempty_q;
        rbin_d          = rbin_q + PW'(rpop);
        rgray_d         = PW'(bin2gray(PTR_W_MAX'(rbin_d)));
        rlevel_d        = PW'(gray2bin(PTR_W_MAX'(wgray_sync))) - rbin_d;
        rempty_d        = (rlevel_d == '0);
        ralmost_empty_d = (rlevel_d <= aempty_thresh);
        rvalid_d        = rpop;
        rdata_d         = rpop ? mem[rbin_q[ASIZE-1:0]] : rdata_q;
        runderflow_d    = runderflow_q || (rinc && rempty_q);
    end

    always_ff @(posedge rclk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            rbin_q          <= '0;
            rgray_q         <= '0;
            rlevel_q        <= '0;
            rempty_q        <= 1'b1;
            ralmost_empty_q <= 1'b1;
            rvalid_q        <= 1'b0;
            rdata_q         <= '0;
            runderflow_q    <= 1'b0;
        end else begin
            rbin_q          <= rbin_d;
            rgray_q         <= rgray_d;
            rlevel_q        <= rlevel_d;
            rempty_q        <= rempty_d;
            ralmost_empty_q <= ralmost_empty_d;
            rvalid_q        <= rvalid_d;
            rdata_q         <= rdata_d;
            runderflow_q    <= runderflow_d;
        end
    end

    assign wfull         = wfull_q;
    // A zero threshold is always met, including while the write side sits in reset.
    assign walmost_full  = walmost_full_q || (afull_thresh == '0);
    assign wlevel        = wlevel_q;
    assign woverflow     = woverflow_q;
    assign rdata         = rdata_q;
    assign rvalid        = rvalid_q;
    assign rempty        = rempty_q;
    assign ralmost_empty = ralmost_empty_q;
    assign rlevel        = rlevel_q;
    assign runderflow    = runderflow_q;

endmodule

// File: tb/tb_afifo_prog.sv
// Scoreboard bench for afifo_prog: data queue and expected-rvalid queue checked by a read-side monitor.
`timescale 1ns/100ps
module tb_afifo_prog;

    localparam int DSIZE = 8;
    localparam int ASIZE = 4;
    localparam int SYNC_STAGES = 2;
    localparam int DEPTH = 16;

    logic             wclk = 1'b0;
    logic             rclk = 1'b0;
    logic             rrst_n = 1'b1;
    logic [DSIZE-1:0] wdata = '0;
    logic             winc = 1'b0;
    logic             rinc = 1'b0;
    logic [ASIZE:0]   afull_thresh = 5'd12;
    logic [ASIZE:0]   aempty_thresh = 5'd2;
    logic             wfull, walmost_full, woverflow;
    logic [ASIZE:0]   wlevel, rlevel;
    logic [DSIZE-1:0] rdata;
    logic             rvalid, rempty, ralmost_empty, runderflow;

    always #5 wclk = ~wclk;
    always #8.5 rclk = ~rclk;

    afifo_prog #(.DSIZE(DSIZE), .ASIZE(ASIZE), .SYNC_STAGES(SYNC_STAGES)) dut (
        .wclk          (wclk),
        .rrst_n        (rrst_n),
        .rclk          (rclk),
        .wdata         (wdata),
        .winc          (winc),
        .afull_thresh  (afull_thresh),
        .wfull         (wfull),
        .walmost_full  (walmost_full),
        .wlevel        (wlevel),
        .woverflow     (woverflow),
        .rinc          (rinc),
        .aempty_thresh (aempty_thresh),
        .rdata         (rdata),
        .rvalid        (rvalid),
        .rempty        (rempty),
        .ralmost_empty (ralmost_empty),
        .rlevel        (rlevel),
        .runderflow    (runderflow)
    );

    int checks = 0;
    int errors = 0;
    logic [DSIZE-1:0] sb_data[$];
    logic             exp_rv_q[$];
    int wr_done = 0;
    int rd_issued = 0;
    int rx_count = 0;
    logic thr_watch = 1'b0;
    int af_viol = 0;
    int ae_viol = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_ge(input string name, input int act, input int bound);
        checks++;
        if (!(act >= bound)) begin
            errors++;
            $display("FAIL %s: got %0d expected at least %0d", name, act, bound);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_wfull"}, 32'(wfull), 32'd0);
        check({tag, "_walmost_full"}, 32'(walmost_full), 32'd0);
        check({tag, "_wlevel"}, 32'(wlevel), 32'd0);
        check({tag, "_woverflow"}, 32'(woverflow), 32'd0);
        check({tag, "_rempty"}, 32'(rempty), 32'd1);
        check({tag, "_ralmost_empty"}, 32'(ralmost_empty), 32'd1);
        check({tag, "_rlevel"}, 32'(rlevel), 32'd0);
        check({tag, "_rdata"}, 32'(rdata), 32'd0);
        check({tag, "_rvalid"}, 32'(rvalid), 32'd0);
        check({tag, "_runderflow"}, 32'(runderflow), 32'd0);
    endtask

    // A write is accepted when winc meets a deasserted wfull at the edge.
    task automatic do_write(input logic [DSIZE-1:0] d, output logic acc);
        @(negedge wclk);
        winc = 1'b1;
        wdata = d;
        acc = !wfull;
        if (acc) sb_data.push_back(d);
        @(negedge wclk);
        winc = 1'b0;
        if (acc) wr_done++;
    endtask

    task automatic do_read();
        @(negedge rclk);
        rinc = 1'b1;
        exp_rv_q.push_back(!rempty);
        if (!rempty) rd_issued++;
        @(negedge rclk);
        rinc = 1'b0;
    endtask

    always @(posedge rclk) begin : monitor
        logic exp_rv;
        #1;
        exp_rv = 1'b0;
        if (exp_rv_q.size() > 0) exp_rv = exp_rv_q.pop_front();
        check("rvalid", 32'(rvalid), 32'(exp_rv));
        if (rvalid === 1'b1) begin
            if (sb_data.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rdata_unexpected: got %0h expected no word", rdata);
            end else begin
                check("rdata", 32'(rdata), 32'(sb_data.pop_front()));
                rx_count++;
            end
        end
    end

    always @(negedge wclk) if (thr_watch && walmost_full !== 1'b1) af_viol++;
    always @(negedge rclk) if (thr_watch && ralmost_empty !== 1'b1) ae_viol++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        int n;
        int target;

        #1 rrst_n = 1'b0;
        #19;
        check_reset_values("rst");
        rrst_n = 1'b1;
        repeat (4) @(negedge rclk);

        for (int i = 0; i < DEPTH; i++) begin
            do_write(8'(i), acc);
            check("fill_acc", 32'(acc), 32'd1);
            check("fill_wlevel", 32'(wlevel), 32'(sb_data.size()));
            check("fill_afull", 32'(walmost_full), 32'(sb_data.size() >= 12));
            check("fill_wfull", 32'(wfull), 32'(sb_data.size() == DEPTH));
        end
        check("ovf_before", 32'(woverflow), 32'd0);
        do_write(8'hEE, acc);
        check("ovf_dropped", 32'(acc), 32'd0);
        check("ovf_set", 32'(woverflow), 32'd1);
        check("ovf_wlevel", 32'(wlevel), 32'd16);

        repeat (6) @(negedge rclk);
        check("full_rlevel", 32'(rlevel), 32'd16);
        check("full_rempty", 32'(rempty), 32'd0);
        check("full_raempty", 32'(ralmost_empty), 32'd0);

        for (int i = 0; i < DEPTH; i++) begin
            do_read();
            check("drain_rlevel", 32'(rlevel), 32'(sb_data.size()));
            check("drain_raempty", 32'(ralmost_empty), 32'(sb_data.size() <= 2));
            check("drain_rempty", 32'(rempty), 32'(sb_data.size() == 0));
        end
        check("udf_before", 32'(runderflow), 32'd0);
        do_read();
        check("udf_set", 32'(runderflow), 32'd1);
        repeat (6) @(negedge wclk);
        check("drain_wlevel", 32'(wlevel), 32'd0);
        check("drain_wfull", 32'(wfull), 32'd0);
        check("drain_wafull", 32'(walmost_full), 32'd0);

        @(negedge wclk);
        winc = 1'b1;
        wdata = 8'h3C;
        sb_data.push_back(8'h3C);
        @(posedge wclk);
        #1 winc = 1'b0;
        wr_done++;
        n = 0;
        while (rempty && n < 10) begin
            @(posedge rclk);
            #1 n++;
        end
        check("lat_edges", 32'(n), 32'(1 + SYNC_STAGES));
        check("lat_rlevel", 32'(rlevel), 32'd1);
        do_read();
        repeat (2) @(negedge rclk);

        target = rx_count + 100;
        fork
            begin : writer
                logic wacc;
                for (int i = 0; i < 100; i++) begin
                    do_write(8'($urandom), wacc);
                    check("wrap_no_full", 32'(wacc), 32'd1);
                    check_ge("wrap_wlevel_cons", int'(wlevel), wr_done - rd_issued);
                end
            end
            begin : reader
                int guard;
                guard = 0;
                while (rx_count < target && guard < 4000) begin
                    @(negedge rclk);
                    rinc = 1'b1;
                    exp_rv_q.push_back(!rempty);
                    if (!rempty) rd_issued++;
                    guard++;
                end
                @(negedge rclk);
                rinc = 1'b0;
            end
        join
        repeat (2) @(negedge rclk);
        check("wrap_count", 32'(rx_count), 32'(target));
        check("wrap_left", 32'(sb_data.size()), 32'd0);

        for (int i = 0; i < 7; i++) do_write(8'(16 + i), acc);
        repeat (6) @(negedge rclk);
        check("mid_rlevel", 32'(rlevel), 32'd7);
        @(negedge wclk);
        #1 rrst_n = 1'b0;
        #1.5;
        check_reset_values("mid");
        #1.5 rrst_n = 1'b1;
        sb_data.delete();
        wr_done = 0;
        rd_issued = 0;
        repeat (4) @(negedge rclk);
        check("post_rempty", 32'(rempty), 32'd1);
        check("post_rlevel", 32'(rlevel), 32'd0);
        check("post_wlevel", 32'(wlevel), 32'd0);
        do_write(8'hA5, acc);
        repeat (6) @(negedge rclk);
        do_read();
        repeat (2) @(negedge rclk);
        check("post_readback_done", 32'(sb_data.size()), 32'd0);

        rrst_n = 1'b0;
        afull_thresh = 5'd0;
        aempty_thresh = 5'd16;
        #20;
        check("thr_rst_wafull", 32'(walmost_full), 32'd1);
        check("thr_rst_raempty", 32'(ralmost_empty), 32'd1);
        rrst_n = 1'b1;
        thr_watch = 1'b1;
        repeat (4) @(negedge rclk);
        for (int i = 0; i < DEPTH; i++) do_write(8'(8'h40 + i), acc);
        check("thr_full", 32'(wfull), 32'd1);
        repeat (6) @(negedge rclk);
        for (int i = 0; i < DEPTH; i++) do_read();
        repeat (6) @(negedge wclk);
        thr_watch = 1'b0;
        check("thr_af_viol", 32'(af_viol), 32'd0);
        check("thr_ae_viol", 32'(ae_viol), 32'd0);
        check("thr_left", 32'(sb_data.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/afifo_prog.md
# afifo_prog

Parametrised dual-clock FIFO with registered read data, fill-level reporting in both domains, programmable almost-full/almost-empty thresholds and sticky overflow/underflow error flags. It sits at each clock-domain crossing in the datapath and supersedes the fixed-flag FIFO. Producers use the write-side flags for back-pressure and burst decisions. Consumers use the read-side level and flags to schedule bursts.

## Interface
- DSIZE, 8: data width in bits.
- ASIZE, 4: address width; DEPTH = 2**ASIZE entries; ASIZE >= 2.
- SYNC_STAGES, 2: flip-flop stages per Gray-pointer synchroniser; must be >= 2.
- wclk  in  1  write clock.
- rrst_n  in  1  reset, asynchronous, active-low; clears both domains.
- rclk  in  1  read clock.
- wdata  in  DSIZE  write data.
- winc  in  1  write request.
- afull_thresh  in  ASIZE+1  almost-full threshold, in entries; quasi-static.
- wfull  out  1  FIFO full (wclk domain).
- walmost_full  out  1  wlevel >= afull_thresh.
- wlevel  out  ASIZE+1  write-side fill level, 0..DEPTH.
- woverflow  out  1  sticky flag: write attempted while full.
- rinc  in  1  read request.
- aempty_thresh  in  ASIZE+1  almost-empty threshold; quasi-static.
- rdata  out  DSIZE  registered read data.
- rvalid  out  1  rdata holds a word popped on the previous rclk edge.
- rempty  out  1  FIFO empty (rclk domain).
- ralmost_empty  out  1  rlevel <= aempty_thresh.
- rlevel  out  ASIZE+1  read-side fill level, 0..DEPTH.
- runderflow  out  1  sticky flag: read attempted while empty.

## Operation
- Reset assertion clears both domains asynchronously. Each domain has its own 2-FF reset synchroniser, so deassertion is released after 2 edges of that domain's clock.
- Reset values: wfull 0, walmost_full 0 (1 if afull_thresh == 0), wlevel 0, woverflow 0, rempty 1, ralmost_empty 1, rlevel 0, rdata 0, rvalid 0, runderflow 0.
- Memory contents are not reset.
- Pointers are ASIZE+1 bits wide, in binary plus registered Gray form. Only the Gray form crosses domains. Wrap-around from 2**(ASIZE+1)-1 to 0 is a single-bit Gray change.
- Write accepted iff winc && !wfull.
  - Memory is written at wbin[ASIZE-1:0].
  - wbin increments by 1.
- winc && wfull: the write is dropped, pointers are unchanged, and woverflow sets. woverflow stays set until reset.
- Read accepted iff rinc && !rempty.
  - rdata is loaded from mem[rbin[ASIZE-1:0]] and rbin increments.
  - rvalid is 1 on the following cycle, otherwise 0.
  - rdata holds its value when no read is accepted.
- rinc && rempty: no pop, rvalid 0, and runderflow sets (sticky).
- Levels are computed modulo 2**(ASIZE+1) from registered next-state values:
  - wlevel <= wbinnext - gray2bin(synchronised rptr).
  - rlevel <= gray2bin(synchronised wptr) - rbinnext.
- Flags are registered:
  - wfull <= (wlevel_next == DEPTH).
  - walmost_full <= (wlevel_next >= afull_thresh).
  - rempty <= (rlevel_next == 0).
  - ralmost_empty <= (rlevel_next <= aempty_thresh).
- Flags are conservative:
  - wlevel may overstate and rlevel may understate the true occupancy, never the reverse.
  - wfull never deasserts while DEPTH entries are unread.
  - rempty never deasserts with no data present.
- Thresholds may only change while rrst_n is asserted. Threshold values > DEPTH are legal: walmost_full then never asserts and ralmost_empty always asserts.
- Simultaneous write at full and read in the other domain: the write is still dropped, because the registered wfull decides.

## Timing
- Write-to-read visibility: a write on wclk edge N updates wptr at edge N. rempty/rlevel then update 1 + SYNC_STAGES rclk edges after the pointer is captured.
- Read-to-write visibility: symmetric, 1 + SYNC_STAGES wclk edges.
- Read latency: rinc accepted at rclk edge N gives rdata/rvalid valid from edge N until N+1.
- Flags and levels change one cycle after the causing local operation.
- Reset mid-operation: all outputs return to their reset values asynchronously. The FIFO restarts empty; any in-flight data is discarded.

## Structure
- Package afifo_pkg contains:
  - function bin2gray(ASIZE+1);
  - function gray2bin(ASIZE+1);
  - localparam helper for DEPTH.
- One sub-module, afifo_gray_sync: a SYNC_STAGES-deep synchroniser with asynchronous active-low reset. It is instantiated twice, once per direction.
- The reset synchronisers and memory array are inline in afifo_prog.

## Test plan
Common setup for all scenarios: DSIZE=8, ASIZE=4, SYNC_STAGES=2, wclk 10 ns, rclk 17 ns, afull_thresh=12, aempty_thresh=2.
- Fill: write 16 words 0x00..0x0F with no reads.
  - walmost_full rises on the cycle after the 12th write.
  - wfull rises after the 16th write; wlevel = 16.
  - A 17th winc sets woverflow and leaves memory unchanged.
- Drain: read 16 words.
  - rdata sequence is 0x00..0x0F, each with rvalid one cycle after rinc.
  - ralmost_empty rises when rlevel <= 2; rempty rises after the last read.
  - An extra rinc sets runderflow with rvalid 0.
- Latency: a single write to the empty FIFO deasserts rempty exactly 3 rclk edges after the wptr update; rlevel becomes 1.
- Wrap-around: stream 100 words continuously at 50% write duty.
  - Data arrive in order with none lost or duplicated.
  - Pointers wrap at 32 without any spurious full or empty.
- Reset mid-operation: with 7 words stored, pulse rrst_n low for 3 ns.
  - All outputs take reset values immediately.
  - After release, a write of 0xA5 reads back as 0xA5.
- Thresholds: with afull_thresh=0 and aempty_thresh=16, walmost_full and ralmost_empty stay at 1 for the whole run.
